seven_segment_fun: RTL and testbench



---
 rtl/seven_segment_fun.sv | 145 ++++++++++++++
 tb/tb_seven_segment_fun.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_fun.sv
// Four-button hex digit editor driving a common-cathode seven-segment display.
// Buttons are synchronized and debounced; rising debounced edges edit the value.
module seven_segment_fun #(
    parameter int DEBOUNCE_LEN = 4,
    parameter int AUTO_DIV     = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CNT_W = $clog2(DEBOUNCE_LEN + 1);
    localparam int PRE_W = $clog2(AUTO_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

    // Segment pattern for one hex digit, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       deb_r;
    logic [3:0]       deb_d_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [3:0]       value_r;
    logic             auto_r;
    logic [PRE_W-1:0] presc_r;

    logic [3:0]       press_s;
    logic             tick_s;
    logic [3:0]       value_nxt_s;
    logic             auto_nxt_s;
    logic [PRE_W-1:0] presc_nxt_s;
    logic             unused_s;

    assign unused_s = &{1'b0, ena, uio_in, ui_in[7:4]};

    // Synchronizers, debounce counters and the delayed debounced state for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'h0;
            sync2_r <= 4'h0;
            deb_r   <= 4'h0;
            deb_d_r <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r <= ui_in[3:0];
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    // Enough consecutive disagreeing samples: accept the new level.
                    deb_r[i] <= ~deb_r[i];
                    cnt_r[i] <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Press decoding, value priority (clear > inc > dec > tick) and prescaler next state.
    always_comb begin
        press_s     = deb_r & ~deb_d_r;
        tick_s      = auto_r && (presc_r == PRE_LAST);
        value_nxt_s = value_r;
        auto_nxt_s  = auto_r ^ press_s[2];
        presc_nxt_s = presc_r;
        if (press_s[3]) begin
            value_nxt_s = 4'h0;
        end else if (press_s[0]) begin
            value_nxt_s = value_r + 4'h1;
        end else if (press_s[1]) begin
            value_nxt_s = value_r - 4'h1;
        end else if (tick_s) begin
            value_nxt_s = value_r + 4'h1;
        end else begin
            value_nxt_s = value_r;
        end
        // A toggle restarts the period; a tick swallowed by a manual press still wraps.
        if (press_s[2]) begin
            presc_nxt_s = PRE_ZERO;
        end else if (auto_r) begin
            if (tick_s) begin
                presc_nxt_s = PRE_ZERO;
            end else begin
                presc_nxt_s = presc_r + PRE_ONE;
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Digit value, auto-mode flag and prescaler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= 4'h0;
            auto_r  <= 1'b0;
            presc_r <= PRE_ZERO;
        end else begin
            value_r <= value_nxt_s;
            auto_r  <= auto_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    assign uo_out  = {auto_r, seg_decode(value_r)};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_seven_segment_fun.sv
// Self-checking bench for seven_segment_fun: directed vector table, cycle-exact
// corner sequences and a randomized run against a behavioural model.
module tb_seven_segment_fun;
    localparam int DLEN = 4;
    localparam int ADIV = 16;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [3:0] btn;
        logic [7:0] exp;
    } vec_t;

    seven_segment_fun #(.DEBOUNCE_LEN(DLEN), .AUTO_DIV(ADIV)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: raw button samples per edge, debounced levels, value, auto.
    logic [3:0] hist [$];
    int         n_edge;
    logic [3:0] m_deb;
    logic [3:0] m_pend;
    logic [3:0] m_val;
    logic       m_auto;
    int         m_tog;

    task automatic model_reset();
        hist.delete();
        n_edge = 0;
        m_deb  = 4'h0;
        m_pend = 4'h0;
        m_val  = 4'h0;
        m_auto = 1'b0;
        m_tog  = 0;
    endtask

    task automatic model_edge(input logic [3:0] ui);
        logic tick;
        tick = m_auto && (n_edge > m_tog) && (((n_edge - m_tog) % ADIV) == 0);
        if (m_pend[3])      m_val = 4'h0;
        else if (m_pend[0]) m_val = m_val + 4'h1;
        else if (m_pend[1]) m_val = m_val - 4'h1;
        else if (tick)      m_val = m_val + 4'h1;
        if (m_pend[2]) begin
            m_auto = !m_auto;
            m_tog  = n_edge;
        end
        hist.push_back(ui);
        m_pend = 4'h0;
        // The level seen by the filter at edge n was sampled from the pins at edge n-2.
        for (int b = 0; b < 4; b++) begin
            bit   stable;
            int   k;
            logic lvl;
            stable = 1'b1;
            for (int j = 0; j < DLEN; j++) begin
                k   = n_edge - 2 - j;
                lvl = (k >= 0) ? hist[k][b] : 1'b0;
                if (lvl == m_deb[b]) stable = 1'b0;
            end
            if (stable) begin
                m_deb[b] = ~m_deb[b];
                if (m_deb[b]) m_pend[b] = 1'b1;
            end
        end
        n_edge++;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] btn);
        ui_in = {4'h0, btn};
        repeat (8) step();
        ui_in = 8'h00;
        repeat (8) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        model_reset();
    endtask

    vec_t       vecs [15];
    int         hold_left [4];
    logic [3:0] lvl;
    logic [3:0] v;
    logic       dp;

    initial begin
        vecs[0]  = '{4'b0001, 8'h06};
        vecs[1]  = '{4'b0010, 8'h3F};
        vecs[2]  = '{4'b0010, 8'h71};
        vecs[3]  = '{4'b0001, 8'h3F};
        vecs[4]  = '{4'b0001, 8'h06};
        vecs[5]  = '{4'b0001, 8'h5B};
        vecs[6]  = '{4'b1000, 8'h3F};
        vecs[7]  = '{4'b1001, 8'h3F};
        vecs[8]  = '{4'b0011, 8'h06};
        vecs[9]  = '{4'b1010, 8'h3F};
        vecs[10] = '{4'b0010, 8'h71};
        vecs[11] = '{4'b0010, 8'h79};
        vecs[12] = '{4'b0010, 8'h5E};
        vecs[13] = '{4'b0010, 8'h39};
        vecs[14] = '{4'b0001, 8'h5E};

        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #3;
        check("reset_uo", uo_out, 8'h3F);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("after_reset_uo", uo_out, 8'h3F);

        // Single-cycle chatter on each button must be rejected.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                ui_in    = 8'h00;
                ui_in[k] = (i % 2 == 0);
                step();
            end
            ui_in = 8'h00;
            repeat (10) step();
            check($sformatf("chatter_btn%0d", k + 1), uo_out, 8'h3F);
        end

        // Held button: one increment exactly at edge 6, nothing afterwards.
        ui_in = 8'h01;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("hold_edge%0d", i), uo_out, (i >= 6) ? 8'h06 : 8'h3F);
        end
        ui_in = 8'h00;
        repeat (8) step();
        for (int i = 0; i < 15; i++) press(4'b0001);
        check("wrap_after_16", uo_out, 8'h3F);

        for (int i = 0; i < 15; i++) begin
            press(vecs[i].btn);
            check($sformatf("vec%0d", i), uo_out, vecs[i].exp);
        end

        // Auto mode on, two ticks, then off again before the third tick.
        press(4'b1000);
        for (int i = 0; i <= 80; i++) begin
            ui_in = ((i < 8) || (i >= 41 && i < 49)) ? 8'h04 : 8'h00;
            step();
            dp = (i >= 6) && (i < 47);
            v  = (i >= 38) ? 4'h2 : (i >= 22) ? 4'h1 : 4'h0;
            check($sformatf("auto_edge%0d", i), uo_out, {dp, seg_tab[v]});
        end

        // Increment pulse landing on the tick edge counts once.
        press(4'b1000);
        for (int i = 0; i <= 60; i++) begin
            ui_in = ((i < 8) ? 8'h04 : 8'h00) | ((i >= 32 && i < 40) ? 8'h01 : 8'h00);
            step();
            v = (i >= 54) ? 4'h3 : (i >= 38) ? 4'h2 : (i >= 22) ? 4'h1 : 4'h0;
            check($sformatf("tick_inc_edge%0d", i), uo_out, {(i >= 6), seg_tab[v]});
        end

        // Reset in the middle of a debounce, button kept held through release.
        ui_in = 8'h01;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("midreset_async", uo_out, 8'h3F);
        repeat (2) step();
        check("midreset_held", uo_out, 8'h3F);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("post_reset_edge%0d", i), uo_out, (i >= 6) ? 8'h06 : 8'h3F);
        end
        ui_in = 8'h00;

        // Randomized run against the model.
        do_reset();
        lvl = 4'h0;
        for (int b = 0; b < 4; b++) hold_left[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b]       = 1'($urandom_range(0, 1));
                    hold_left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                                : int'($urandom_range(4, 14));
                end
                hold_left[b]--;
            end
            ui_in  = {4'($urandom), lvl};
            uio_in = 8'($urandom);
            ena    = 1'($urandom);
            @(posedge clk);
            model_edge(ui_in[3:0]);
            #1;
            check("random_uo", uo_out, {m_auto, seg_tab[m_val]});
        end
        check("random_uio_out", uio_out, 8'h00);
        check("random_uio_oe", uio_oe, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
